// File: rtl/conv_layer_sched_if.sv
// rtl/conv_layer_sched_if.sv - host and engine handshake bundle for the conv layer scheduler
// master is the scheduler side; slave is the host/engine side.
interface conv_layer_sched_if #(
   parameter int OC_GRP_W = 4,
   parameter int TILE_W   = 8
);
   logic                layer_start;
   logic                abort;
   logic [OC_GRP_W-1:0] num_oc_grp;
   logic [TILE_W-1:0]   num_tile;
   logic                param_load;
   logic                param_done;
   logic                tile_start;
   logic                tile_done;
   logic [OC_GRP_W-1:0] oc_grp_idx;
   logic [TILE_W-1:0]   tile_idx;
   logic                layer_busy;
   logic                layer_done;

   modport master (
      input  layer_start, abort, num_oc_grp, num_tile, param_done, tile_done,
      output param_load, tile_start, oc_grp_idx, tile_idx, layer_busy, layer_done
   );

   modport slave (
      output layer_start, abort, num_oc_grp, num_tile, param_done, tile_done,
      input  param_load, tile_start, oc_grp_idx, tile_idx, layer_busy, layer_done
   );
endinterface

// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - walks one conv layer as OC groups x spatial tiles
// One param reload per group, then one start/done handshake per tile.
module conv_layer_sched #(
   parameter int OC_GRP_W = 4,
   parameter int TILE_W   = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   conv_layer_sched_if.master  sched
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_P = 3'd1,
      WAIT_P = 3'd2,
      RUN_T  = 3'd3,
      WAIT_T = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [OC_GRP_W-1:0] grp_q, grp_d;
   logic [TILE_W-1:0]   tile_q, tile_d;
   logic [OC_GRP_W-1:0] ngrp_q, ngrp_d;
   logic [TILE_W-1:0]   ntile_q, ntile_d;
   logic                last_tile;
   logic                last_grp;

   // Terminal compares use the latched counts; they are never zero outside IDLE/DONE.
   assign last_tile = (tile_q == (ntile_q - TILE_W'(1)));
   assign last_grp  = (grp_q == (ngrp_q - OC_GRP_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grp_q   <= '0;
         tile_q  <= '0;
         ngrp_q  <= '0;
         ntile_q <= '0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         tile_q  <= tile_d;
         ngrp_q  <= ngrp_d;
         ntile_q <= ntile_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      tile_d  = tile_q;
      ngrp_d  = ngrp_q;
      ntile_d = ntile_q;
      if (sched.abort) begin
         state_d = IDLE;
         grp_d   = '0;
         tile_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (sched.layer_start) begin
                  ngrp_d  = sched.num_oc_grp;
                  ntile_d = sched.num_tile;
                  grp_d   = '0;
                  tile_d  = '0;
                  if ((sched.num_oc_grp == '0) || (sched.num_tile == '0)) begin
                     state_d = DONE;
                  end else begin
                     state_d = LOAD_P;
                  end
               end
            end
            LOAD_P: state_d = WAIT_P;
            WAIT_P: begin
               if (sched.param_done) begin
                  state_d = RUN_T;
               end
            end
            RUN_T: state_d = WAIT_T;
            WAIT_T: begin
               if (sched.tile_done) begin
                  if (!last_tile) begin
                     tile_d  = tile_q + TILE_W'(1);
                     state_d = RUN_T;
                  end else if (!last_grp) begin
                     grp_d   = grp_q + OC_GRP_W'(1);
                     tile_d  = '0;
                     state_d = LOAD_P;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            DONE: state_d = IDLE;
            default: begin
               state_d = IDLE;
               grp_d   = '0;
               tile_d  = '0;
            end
         endcase
      end
   end

   assign sched.param_load = (state_q == LOAD_P);
   assign sched.tile_start = (state_q == RUN_T);
   assign sched.layer_done = (state_q == DONE);
   assign sched.layer_busy = (state_q == LOAD_P) || (state_q == WAIT_P) ||
                             (state_q == RUN_T)  || (state_q == WAIT_T);
   assign sched.oc_grp_idx = grp_q;
   assign sched.tile_idx   = tile_q;

endmodule
